patch_router_scan: RTL and testbench

- Continuously scans the front-panel patch jacks and reconstructs the signal chain from the dry source through up to N_FX effects to the master output.
- Generalises the fixed five-effect patch reader: the effect count and settle time are parameters.
- Adds sense-input synchronisation, explicit error detection (open chain, split cable, loop), held-last-good outputs and a change strobe.
- Sits between the jack I/O pins and the audio mux select logic.

---
 rtl/patch_pkg.sv | 22 ++
 rtl/patch_sink_decode.sv | 30 +++
 rtl/patch_router_scan.sv | 225 ++++++++++++++++++++++
 tb/tb_patch_router_scan.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/patch_pkg.sv
// rtl/patch_pkg.sv - shared enums and helpers for the patch-jack scanner
package patch_pkg;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_NO_SINK    = 2'd1,
    ERR_MULTI_SINK = 2'd2,
    ERR_LOOP       = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    WALK   = 2'd1,
    COMMIT = 2'd2
  } state_e;

  // All-ones source code of the given width; wide enough for N_FX up to 14.
  function automatic logic [3:0] src_none(input int unsigned w);
    return 4'((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/patch_sink_decode.sv
// rtl/patch_sink_decode.sv - classifies one source's sensed sinks as none, single or multiple
module patch_sink_decode #(
  parameter int N_FX  = 5,
  parameter int SRC_W = $clog2(N_FX + 2)
) (
  input  logic [N_FX:0]    conn,
  output logic             one_hot_ok,
  output logic             zero,
  output logic             multi,
  output logic [SRC_W-1:0] sink
);

  int unsigned hits;

  always_comb begin
    hits = 0;
    sink = '0;
    for (int i = 0; i <= N_FX; i++) begin
      if (conn[i]) begin
        hits = hits + 1;
        sink = SRC_W'(i);
      end
    end
  end

  assign zero       = (hits == 0);
  assign one_hot_ok = (hits == 1);
  assign multi      = (hits > 1);

endmodule

// File: rtl/patch_router_scan.sv
// rtl/patch_router_scan.sv - scans patch jacks and commits the dry-to-master signal chain
// Build option PATCH_STABLE_CHECK_EN: commit only after two consecutive identical walks.
module patch_router_scan
  import patch_pkg::*;
#(
  parameter int N_FX   = 5,
  parameter int SETTLE = 192,
  parameter int SRC_W  = $clog2(N_FX + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [N_FX:0]         drive_n,
  input  logic [N_FX:0]         sense,
  output logic [N_FX*SRC_W-1:0] fx_src,
  output logic [SRC_W-1:0]      out_src,
  output logic                  update,
  output logic                  err,
  output logic [1:0]            err_code
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SRC_W-1:0] DRY      = SRC_W'(N_FX);
  localparam logic [SRC_W-1:0] NONE     = SRC_W'(src_none(SRC_W));
  localparam logic [SRC_W-1:0] STEP_MAX = SRC_W'(N_FX + 1);

  typedef logic [N_FX-1:0][SRC_W-1:0] map_t;
  localparam map_t MAP_NONE = {N_FX{NONE}};

  state_e                state_q, state_d;
  logic [SRC_W-1:0]      probe_q, probe_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_FX:0]         sync1_q, sync1_d, sync2_q, sync2_d;
  logic [N_FX:0]         drive_n_q, drive_n_d;
  logic [N_FX:0][N_FX:0] conn_q, conn_d;
  logic [SRC_W-1:0]      cur_q, cur_d, step_q, step_d;
  logic [N_FX:0]         visited_q, visited_d;
  map_t                  new_fx_q, new_fx_d, fx_src_q, fx_src_d;
  logic [SRC_W-1:0]      new_out_q, new_out_d, out_src_q, out_src_d;
  logic                  update_q, update_d, err_q, err_d;
  err_code_e             err_code_q, err_code_d;
`ifdef PATCH_STABLE_CHECK_EN
  map_t                  cand_fx_q, cand_fx_d;
  logic [SRC_W-1:0]      cand_out_q, cand_out_d;
  logic                  cand_valid_q, cand_valid_d;
`endif

  logic             dec_ok, dec_zero, dec_multi;
  logic [SRC_W-1:0] dec_sink;
  logic             fail, do_commit;
  err_code_e        fail_code;
  logic [N_FX:0]    self_mask;

  patch_sink_decode #(.N_FX(N_FX), .SRC_W(SRC_W)) u_decode (
    .conn       (conn_q[cur_q]),
    .one_hot_ok (dec_ok),
    .zero       (dec_zero),
    .multi      (dec_multi),
    .sink       (dec_sink)
  );

  always_comb begin
    sync1_d    = sense;
    sync2_d    = sync1_q;
    state_d    = state_q;
    probe_d    = probe_q;
    cnt_d      = cnt_q;
    conn_d     = conn_q;
    cur_d      = cur_q;
    step_d     = step_q;
    visited_d  = visited_q;
    new_fx_d   = new_fx_q;
    new_out_d  = new_out_q;
    fx_src_d   = fx_src_q;
    out_src_d  = out_src_q;
    update_d   = 1'b0;
    err_d      = err_q;
    err_code_d = err_code_q;
`ifdef PATCH_STABLE_CHECK_EN
    cand_fx_d    = cand_fx_q;
    cand_out_d   = cand_out_q;
    cand_valid_d = cand_valid_q;
`endif
    fail      = 1'b0;
    fail_code = ERR_NONE;
    do_commit = 1'b0;
    // Only an effect's own input is self-sense; dry and master are distinct jacks.
    self_mask = (probe_q == DRY) ? '0 : ({{N_FX{1'b0}}, 1'b1} << probe_q);

    case (state_q)
      SCAN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          conn_d[probe_q] = sync2_q & ~self_mask;
          cnt_d = '0;
          if (probe_q == DRY) begin
            state_d   = WALK;
            probe_d   = '0;
            cur_d     = DRY;
            step_d    = '0;
            visited_d = '0;
            new_fx_d  = MAP_NONE;
          end else begin
            probe_d = probe_q + SRC_W'(1);
          end
        end
      end
      WALK: begin
        if (dec_zero) begin
          fail      = 1'b1;
          fail_code = ERR_NO_SINK;
        end else if (dec_multi) begin
          fail      = 1'b1;
          fail_code = ERR_MULTI_SINK;
        end else if (dec_ok) begin
          if (dec_sink == DRY) begin
            new_out_d = cur_q;
            state_d   = COMMIT;
          end else if (visited_q[dec_sink] || step_q == STEP_MAX) begin
            fail      = 1'b1;
            fail_code = ERR_LOOP;
          end else begin
            new_fx_d[dec_sink]  = cur_q;
            visited_d[dec_sink] = 1'b1;
            cur_d               = dec_sink;
            step_d              = step_q + SRC_W'(1);
          end
        end
      end
      COMMIT: begin
        state_d = SCAN;
        probe_d = '0;
        cnt_d   = '0;
`ifdef PATCH_STABLE_CHECK_EN
        do_commit    = cand_valid_q && (cand_fx_q == new_fx_q) && (cand_out_q == new_out_q);
        cand_fx_d    = new_fx_q;
        cand_out_d   = new_out_q;
        cand_valid_d = 1'b1;
`else
        do_commit = 1'b1;
`endif
        if (do_commit) begin
          fx_src_d   = new_fx_q;
          out_src_d  = new_out_q;
          update_d   = (new_fx_q != fx_src_q) || (new_out_q != out_src_q);
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = SCAN;
    endcase

    if (fail) begin
      err_d      = 1'b1;
      err_code_d = fail_code;
      state_d    = SCAN;
      probe_d    = '0;
      cnt_d      = '0;
`ifdef PATCH_STABLE_CHECK_EN
      cand_valid_d = 1'b0;
`endif
    end

    // Registered so the jack drive never glitches; after reset the first window is one cycle short.
    drive_n_d = (state_d == SCAN) ? ~({{N_FX{1'b0}}, 1'b1} << probe_d) : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SCAN;
      probe_q    <= '0;
      cnt_q      <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      drive_n_q  <= '1;
      conn_q     <= '0;
      cur_q      <= '0;
      step_q     <= '0;
      visited_q  <= '0;
      new_fx_q   <= MAP_NONE;
      new_out_q  <= DRY;
      fx_src_q   <= MAP_NONE;
      out_src_q  <= DRY;
      update_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef PATCH_STABLE_CHECK_EN
      cand_fx_q    <= MAP_NONE;
      cand_out_q   <= DRY;
      cand_valid_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      probe_q    <= probe_d;
      cnt_q      <= cnt_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      drive_n_q  <= drive_n_d;
      conn_q     <= conn_d;
      cur_q      <= cur_d;
      step_q     <= step_d;
      visited_q  <= visited_d;
      new_fx_q   <= new_fx_d;
      new_out_q  <= new_out_d;
      fx_src_q   <= fx_src_d;
      out_src_q  <= out_src_d;
      update_q   <= update_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef PATCH_STABLE_CHECK_EN
      cand_fx_q    <= cand_fx_d;
      cand_out_q   <= cand_out_d;
      cand_valid_q <= cand_valid_d;
`endif
    end
  end

  assign drive_n  = drive_n_q;
  assign fx_src   = fx_src_q;
  assign out_src  = out_src_q;
  assign update   = update_q;
  assign err      = err_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_patch_router_scan.sv
// tb/tb_patch_router_scan.sv - randomized patch-scan bench with a cable-level reference model
module tb_patch_router_scan;

  localparam int N_FX   = 5;
  localparam int SETTLE = 8;
  localparam int SRC_W  = $clog2(N_FX + 2);
  localparam int DRY    = N_FX;
  localparam int NONE   = (1 << SRC_W) - 1;

  // link[source][sink]: a cable from a source jack to a sink jack
  typedef logic [N_FX:0][N_FX:0] patch_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [N_FX:0]         drive_n;
  logic [N_FX:0]         sense;
  logic [N_FX*SRC_W-1:0] fx_src;
  logic [SRC_W-1:0]      out_src;
  logic                  update;
  logic                  err;
  logic [1:0]            err_code;

  patch_t link;
  int     total = 0;
  int     bad = 0;
  int     upd_cnt = 0;
  bit     multi_low = 1'b0;

  int m_fx[N_FX];
  int m_out, m_err, m_code, m_upd;
`ifdef PATCH_STABLE_CHECK_EN
  int c_fx[N_FX];
  int c_out;
  bit c_valid;
`endif

  patch_router_scan #(.N_FX(N_FX), .SETTLE(SETTLE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .drive_n  (drive_n),
    .sense    (sense),
    .fx_src   (fx_src),
    .out_src  (out_src),
    .update   (update),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  always_comb begin
    sense = '0;
    for (int s = 0; s <= N_FX; s++)
      for (int j = 0; j <= N_FX; j++)
        if (link[s][j] && !drive_n[s]) sense[j] = 1'b1;
  end

  always @(negedge clk) begin
    if (rst_n && update) upd_cnt <= upd_cnt + 1;
    if ($countones(~drive_n) > 1) multi_low <= 1'b1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N_FX; i++) m_fx[i] = NONE;
    m_out  = DRY;
    m_err  = 0;
    m_code = 0;
    m_upd  = 0;
`ifdef PATCH_STABLE_CHECK_EN
    c_valid = 1'b0;
`endif
  endtask

  // Follow the cables from the dry jack and apply the outcome to the expected outputs.
  task automatic model_scan(input patch_t p);
    int fx[N_FX];
    bit vis[N_FX];
    int cur, out, code, hit, nh;
    bit go, same;
    for (int i = 0; i < N_FX; i++) begin
      fx[i]  = NONE;
      vis[i] = 1'b0;
    end
    cur  = DRY;
    out  = DRY;
    code = -1;
    for (int it = 0; it < N_FX + 2 && code < 0; it++) begin
      nh  = 0;
      hit = 0;
      for (int j = 0; j <= N_FX; j++)
        if (p[cur][j] && !(j == cur && cur != DRY)) begin
          nh++;
          hit = j;
        end
      if (nh == 0) code = 1;
      else if (nh > 1) code = 2;
      else if (hit == DRY) begin
        out  = cur;
        code = 0;
      end else if (vis[hit]) code = 3;
      else begin
        fx[hit]  = cur;
        vis[hit] = 1'b1;
        cur      = hit;
      end
    end
    if (code < 0) code = 3;
    if (code != 0) begin
      m_err  = 1;
      m_code = code;
`ifdef PATCH_STABLE_CHECK_EN
      c_valid = 1'b0;
`endif
    end else begin
`ifdef PATCH_STABLE_CHECK_EN
      go = c_valid && (c_out == out);
      for (int i = 0; i < N_FX; i++) if (c_fx[i] != fx[i]) go = 1'b0;
      for (int i = 0; i < N_FX; i++) c_fx[i] = fx[i];
      c_out   = out;
      c_valid = 1'b1;
`else
      go = 1'b1;
`endif
      if (go) begin
        same = (out == m_out);
        for (int i = 0; i < N_FX; i++) if (fx[i] != m_fx[i]) same = 1'b0;
        if (!same) m_upd++;
        for (int i = 0; i < N_FX; i++) m_fx[i] = fx[i];
        m_out  = out;
        m_err  = 0;
        m_code = 0;
      end
    end
  endtask

  function automatic logic [N_FX*SRC_W-1:0] exp_fx_vec();
    logic [N_FX*SRC_W-1:0] v;
    for (int i = 0; i < N_FX; i++) v[i*SRC_W +: SRC_W] = SRC_W'(m_fx[i]);
    return v;
  endfunction

  // Returns once the dry-jack probe window ends, i.e. the scan has been sampled.
  task automatic wait_scan_end();
    int n;
    bit low_seen;
    n        = 0;
    low_seen = 1'b0;
    while (n < 400) begin
      @(negedge clk);
      n++;
      if (!drive_n[DRY]) low_seen = 1'b1;
      else if (low_seen) break;
    end
    check("scan_end_timeout", 64'(n >= 400), 64'd0);
  endtask

  task automatic trial(input patch_t p, input string tag);
    wait_scan_end();
    model_scan(link);
    link = p;
    wait_scan_end();
    model_scan(p);
    repeat (N_FX + 4) @(negedge clk);
    check({tag, "_fx_src"}, 64'(fx_src), 64'(exp_fx_vec()));
    check({tag, "_out_src"}, 64'(out_src), 64'(m_out));
    check({tag, "_err"}, 64'(err), 64'(m_err));
    check({tag, "_err_code"}, 64'(err_code), 64'(m_code));
    check({tag, "_updates"}, 64'(upd_cnt), 64'(m_upd));
  endtask

  function automatic patch_t rand_patch();
    patch_t l;
    int perm[N_FX];
    int mode, len, prev, a, b, t;
    l    = '0;
    mode = int'($urandom_range(0, 3));
    if (mode == 3) begin
      for (int s = 0; s <= N_FX; s++)
        for (int j = 0; j <= N_FX; j++)
          if ($urandom_range(0, 5) == 0) l[s][j] = 1'b1;
    end else begin
      for (int i = 0; i < N_FX; i++) perm[i] = i;
      for (int i = 0; i < N_FX - 1; i++) begin
        a       = int'($urandom_range(i, N_FX - 1));
        t       = perm[i];
        perm[i] = perm[a];
        perm[a] = t;
      end
      len  = int'($urandom_range(0, N_FX));
      prev = DRY;
      for (int i = 0; i < len; i++) begin
        l[prev][perm[i]] = 1'b1;
        prev             = perm[i];
      end
      l[prev][DRY] = 1'b1;
      if (mode == 2) begin
        a       = int'($urandom_range(0, N_FX));
        b       = int'($urandom_range(0, N_FX));
        l[a][b] = 1'b1;
      end
    end
    return l;
  endfunction

  initial begin
    patch_t p;
    patch_t last;
    rst_n = 1'b0;
    link  = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_drive_n", 64'(drive_n), 64'({(N_FX + 1){1'b1}}));
    check("rst_out_src", 64'(out_src), 64'(DRY));
    check("rst_fx_src", 64'(fx_src), 64'(exp_fx_vec()));
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_update", 64'(update), 64'd0);
    rst_n = 1'b1;

    p = '0;
    trial(p, "t1_open");
    p = '0; p[DRY][DRY] = 1'b1;
    trial(p, "t2_direct");
    p = '0; p[DRY][0] = 1'b1; p[0][2] = 1'b1; p[2][DRY] = 1'b1;
    trial(p, "t3_chain");
    trial(p, "t3_hold");
    p = '0; p[DRY][0] = 1'b1; p[0][1] = 1'b1; p[1][0] = 1'b1;
    trial(p, "t4_loop");
    p = '0; p[DRY][1] = 1'b1; p[DRY][3] = 1'b1;
    trial(p, "t5_split");
    p = '0; p[DRY][1] = 1'b1; p[1][DRY] = 1'b1;
    trial(p, "t5_fixed");
    trial(p, "t5_hold");

    last = p;
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 2) != 0) last = rand_patch();
      trial(last, $sformatf("rand%0d", n));
    end

    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_drive_n", 64'(drive_n), 64'({(N_FX + 1){1'b1}}));
    check("mid_rst_out_src", 64'(out_src), 64'(DRY));
    check("mid_rst_fx_src", 64'(fx_src), 64'(exp_fx_vec()));
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_err_code", 64'(err_code), 64'd0);
    check("drive_one_low", 64'(multi_low), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
